// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
// Carries the decoded EX/MEM/WB control bundles from the ID stage through the
// ID/EX, EX/MEM and MEM/WB control latches. It resolves branches in EX,
// detects load-use hazards against the instruction in ID, and drives the
// PC-select, PC/IF-ID write enables and the IF/ID flush.
// Optional feature macro: CTRL_PIPE_STATS_EN adds saturating stall/flush
// event counters (stall_cnt, flush_cnt). Without it those ports are absent.
module ctrl_pipeline #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       id_EX,
  input  logic [1:0]       id_MEM,
  input  logic [1:0]       id_WB,
  input  logic             id_Jump,
  input  logic             id_Branch,
  input  logic             id_BranchNot,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_zero,
  output logic [3:0]       ex_EX,
  output logic [1:0]       ex_MEM,
  output logic [1:0]       ex_WB,
  output logic [1:0]       mem_MEM,
  output logic [1:0]       mem_WB,
  output logic [1:0]       wb_WB,
  output logic [1:0]       pc_sel,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush
`ifdef CTRL_PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // ID/EX control latch
  logic [3:0]       ex_ex_reg;
  logic [1:0]       ex_mem_reg;
  logic [1:0]       ex_wb_reg;
  logic [REG_W-1:0] ex_rt_reg;
  logic             ex_branch_reg;
  logic             ex_branchnot_reg;

  // EX/MEM and MEM/WB control latches
  logic [1:0]       mem_mem_reg;
  logic [1:0]       mem_wb_reg;
  logic [1:0]       wb_wb_reg;

  // Hazard / redirect decisions for the current cycle
  logic             take;
  logic             hz;
  logic             bubble;

  // Branch resolution in EX, and load-use detection (only meaningful when the
  // branch is not taken, because a taken branch squashes the ID instruction).
  always_comb begin
    take = (ex_branch_reg & ex_zero) | (ex_branchnot_reg & ~ex_zero);
    hz   = 1'b0;
    if (!take) begin
      hz = ex_mem_reg[1] & (ex_rt_reg != '0) &
           ((ex_rt_reg == id_rs) | (ex_rt_reg == id_rt));
    end
    bubble = take | hz;
  end

  // Front-end control: priority is taken branch, then hazard, then jump.
  always_comb begin
    pc_sel     = PC_SEQ;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    if (take) begin
      pc_sel     = PC_BRANCH;
      ifid_flush = 1'b1;
    end else if (hz) begin
      // Hold PC and IF/ID so the ID instruction is retried next cycle.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (id_Jump) begin
      pc_sel     = PC_JUMP;
      ifid_flush = 1'b1;
    end
  end

  // ID/EX latch: capture the ID bundles, or a bubble on taken branch / hazard.
  // A jump's bundles are all zero from the decoder, so it is captured as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ex_reg        <= '0;
      ex_mem_reg       <= '0;
      ex_wb_reg        <= '0;
      ex_rt_reg        <= '0;
      ex_branch_reg    <= 1'b0;
      ex_branchnot_reg <= 1'b0;
    end else if (bubble) begin
      ex_ex_reg        <= '0;
      ex_mem_reg       <= '0;
      ex_wb_reg        <= '0;
      ex_rt_reg        <= '0;
      ex_branch_reg    <= 1'b0;
      ex_branchnot_reg <= 1'b0;
    end else begin
      ex_ex_reg        <= id_EX;
      ex_mem_reg       <= id_MEM;
      ex_wb_reg        <= id_WB;
      ex_rt_reg        <= id_rt;
      ex_branch_reg    <= id_Branch;
      ex_branchnot_reg <= id_BranchNot;
    end
  end

  // EX/MEM and MEM/WB latches always advance; they are never stalled or flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_mem_reg <= '0;
      mem_wb_reg  <= '0;
      wb_wb_reg   <= '0;
    end else begin
      mem_mem_reg <= ex_mem_reg;
      mem_wb_reg  <= ex_wb_reg;
      wb_wb_reg   <= mem_wb_reg;
    end
  end

  assign ex_EX   = ex_ex_reg;
  assign ex_MEM  = ex_mem_reg;
  assign ex_WB   = ex_wb_reg;
  assign mem_MEM = mem_mem_reg;
  assign mem_WB  = mem_wb_reg;
  assign wb_WB   = wb_wb_reg;

`ifdef CTRL_PIPE_STATS_EN
  // Counter events: index 0 counts stall cycles, index 1 counts IF/ID flushes.
  // hz already excludes cycles where the branch is taken.
  logic [1:0] cnt_evt;
  assign cnt_evt = {ifid_flush, hz};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      // Saturating event counter
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (cnt_evt[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign stall_cnt = g_cnt[0].cnt_reg;
  assign flush_cnt = g_cnt[1].cnt_reg;
`else
  // Counter width is only meaningful with the statistics feature.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed testbench for ctrl_pipeline with a bundle scoreboard: every driven
// ID instruction pushes the bundle ID/EX is expected to capture, and the
// entries are popped and compared as they pass through EX, MEM and WB.
module tb_ctrl_pipeline;

  typedef struct packed {
    logic [3:0] e;
    logic [1:0] m;
    logic [1:0] w;
  } bnd_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] id_EX;
  logic [1:0] id_MEM;
  logic [1:0] id_WB;
  logic       id_Jump, id_Branch, id_BranchNot;
  logic [4:0] id_rs, id_rt;
  logic       ex_zero;
  logic [3:0] ex_EX;
  logic [1:0] ex_MEM, ex_WB, mem_MEM, mem_WB, wb_WB;
  logic [1:0] pc_sel;
  logic       pc_write, ifid_write, ifid_flush;
`ifdef CTRL_PIPE_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int   n_checks;
  int   n_fails;
  int   exp_stall;
  int   exp_flush;
  bnd_t sb[$];
  bnd_t mem_sb[$];
  bnd_t wb_sb[$];

  ctrl_pipeline #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_EX(id_EX), .id_MEM(id_MEM), .id_WB(id_WB),
    .id_Jump(id_Jump), .id_Branch(id_Branch), .id_BranchNot(id_BranchNot),
    .id_rs(id_rs), .id_rt(id_rt), .ex_zero(ex_zero),
    .ex_EX(ex_EX), .ex_MEM(ex_MEM), .ex_WB(ex_WB),
    .mem_MEM(mem_MEM), .mem_WB(mem_WB), .wb_WB(wb_WB),
    .pc_sel(pc_sel), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush)
`ifdef CTRL_PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_reset();
    sb.delete();
    mem_sb.delete();
    wb_sb.delete();
    mem_sb.push_back('0);
    wb_sb.push_back('0);
    wb_sb.push_back('0);
    exp_stall = 0;
    exp_flush = 0;
  endtask

  // One ID-stage cycle: drive inputs, check front-end control, clock, then
  // retire scoreboard entries against the EX/MEM/WB outputs.
  task automatic drive(input string tag,
                       input logic [3:0] e, input logic [1:0] m, input logic [1:0] w,
                       input logic j, input logic b, input logic bn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic z,
                       input logic [1:0] x_sel, input logic x_pcw, input logic x_ifw,
                       input logic x_fl, input logic x_bub);
    bnd_t cur, pm, pw, cap;
    id_EX = e; id_MEM = m; id_WB = w;
    id_Jump = j; id_Branch = b; id_BranchNot = bn;
    id_rs = rs; id_rt = rt; ex_zero = z;
    #2;
    check({tag, ".pc_sel"}, 16'(pc_sel), 16'(x_sel));
    check({tag, ".pc_write"}, 16'(pc_write), 16'(x_pcw));
    check({tag, ".ifid_write"}, 16'(ifid_write), 16'(x_ifw));
    check({tag, ".ifid_flush"}, 16'(ifid_flush), 16'(x_fl));
    cap.e = e; cap.m = m; cap.w = w;
    sb.push_back(x_bub ? bnd_t'('0) : cap);
    if (!x_pcw) exp_stall++;
    if (x_fl) exp_flush++;
    @(posedge clk);
    #1;
    cur = sb.pop_front();
    pm  = mem_sb.pop_front();
    pw  = wb_sb.pop_front();
    check({tag, ".ex_EX"}, 16'(ex_EX), 16'(cur.e));
    check({tag, ".ex_MEM"}, 16'(ex_MEM), 16'(cur.m));
    check({tag, ".ex_WB"}, 16'(ex_WB), 16'(cur.w));
    check({tag, ".mem_MEM"}, 16'(mem_MEM), 16'(pm.m));
    check({tag, ".mem_WB"}, 16'(mem_WB), 16'(pm.w));
    check({tag, ".wb_WB"}, 16'(wb_WB), 16'(pw.w));
    mem_sb.push_back(cur);
    wb_sb.push_back(cur);
`ifdef CTRL_PIPE_STATS_EN
    check({tag, ".stall_cnt"}, stall_cnt, 16'(exp_stall));
    check({tag, ".flush_cnt"}, flush_cnt, 16'(exp_flush));
`endif
    $display("step %-10s pc_sel=%b pcw=%b ifw=%b flush=%b ex=%b/%b/%b mem=%b/%b wb=%b",
             tag, x_sel, x_pcw, x_ifw, x_fl, ex_EX, ex_MEM, ex_WB, mem_MEM, mem_WB, wb_WB);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".ex_EX"}, 16'(ex_EX), 16'h0);
    check({tag, ".ex_MEM"}, 16'(ex_MEM), 16'h0);
    check({tag, ".ex_WB"}, 16'(ex_WB), 16'h0);
    check({tag, ".mem_MEM"}, 16'(mem_MEM), 16'h0);
    check({tag, ".mem_WB"}, 16'(mem_WB), 16'h0);
    check({tag, ".wb_WB"}, 16'(wb_WB), 16'h0);
    check({tag, ".pc_sel"}, 16'(pc_sel), 16'h0);
    check({tag, ".pc_write"}, 16'(pc_write), 16'h1);
    check({tag, ".ifid_write"}, 16'(ifid_write), 16'h1);
    check({tag, ".ifid_flush"}, 16'(ifid_flush), 16'h0);
`ifdef CTRL_PIPE_STATS_EN
    check({tag, ".stall_cnt"}, stall_cnt, 16'h0);
    check({tag, ".flush_cnt"}, flush_cnt, 16'h0);
`endif
    $display("reset %-10s ex=%b/%b/%b mem=%b/%b wb=%b pcw=%b",
             tag, ex_EX, ex_MEM, ex_WB, mem_MEM, mem_WB, wb_WB, pc_write);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    id_EX = '0; id_MEM = '0; id_WB = '0;
    id_Jump = 1'b0; id_Branch = 1'b0; id_BranchNot = 1'b0;
    id_rs = '0; id_rt = '0; ex_zero = 1'b0;
    sb_reset();
    #3;
    check_reset_state("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    //     tag          EX       MEM    WB     J  B  BN  rs  rt  z     sel    pcw ifw fl bub
    drive("idle",      4'b0000, 2'b00, 2'b00, 0, 0, 0,  0,  0,  0,    2'b00, 1,  1,  0, 0);
    // R-type flowing through EX, MEM, WB
    drive("rtype",     4'b0101, 2'b00, 2'b10, 0, 0, 0,  1,  2,  0,    2'b00, 1,  1,  0, 0);
    drive("nop1",      4'b0000, 2'b00, 2'b00, 0, 0, 0,  0,  0,  0,    2'b00, 1,  1,  0, 0);
    drive("nop2",      4'b0000, 2'b00, 2'b00, 0, 0, 0,  0,  0,  0,    2'b00, 1,  1,  0, 0);
    // Load-use: lw $8 then add using $8 -> exactly one stall
    drive("lw8",       4'b1000, 2'b10, 2'b11, 0, 0, 0,  1,  8,  0,    2'b00, 1,  1,  0, 0);
    drive("add_hz",    4'b0101, 2'b00, 2'b10, 0, 0, 0,  8,  9,  0,    2'b00, 0,  0,  0, 1);
    drive("add_retry", 4'b0101, 2'b00, 2'b10, 0, 0, 0,  8,  9,  0,    2'b00, 1,  1,  0, 0);
    // Load to $0 never stalls a user of $0
    drive("lw0",       4'b1000, 2'b10, 2'b11, 0, 0, 0,  3,  0,  0,    2'b00, 1,  1,  0, 0);
    drive("use0",      4'b0101, 2'b00, 2'b10, 0, 0, 0,  0,  0,  0,    2'b00, 1,  1,  0, 0);
    // BNE taken in EX: redirect, flush, bubble
    drive("bne",       4'b0010, 2'b00, 2'b00, 0, 0, 1,  4,  5,  0,    2'b00, 1,  1,  0, 0);
    drive("bne_tk",    4'b0101, 2'b00, 2'b10, 0, 0, 0,  6,  7,  0,    2'b01, 1,  1,  1, 1);
    drive("after_bne", 4'b0000, 2'b00, 2'b00, 0, 0, 0,  0,  0,  0,    2'b00, 1,  1,  0, 0);
    // BEQ with ex_zero=0: not taken
    drive("beq",       4'b0010, 2'b00, 2'b00, 0, 1, 0,  4,  5,  0,    2'b00, 1,  1,  0, 0);
    drive("beq_nt",    4'b0101, 2'b00, 2'b10, 0, 0, 0,  6,  7,  0,    2'b00, 1,  1,  0, 0);
    // Taken BEQ in EX while a jump sits in ID: branch wins, jump squashed
    drive("beq2",      4'b0010, 2'b00, 2'b00, 0, 1, 0,  4,  5,  0,    2'b00, 1,  1,  0, 0);
    drive("jmp_sq",    4'b0000, 2'b00, 2'b00, 1, 0, 0,  0,  0,  1,    2'b01, 1,  1,  1, 1);
    drive("post_sq",   4'b0000, 2'b00, 2'b00, 0, 0, 0,  0,  0,  1,    2'b00, 1,  1,  0, 0);
    // Plain jump: pc_sel=10, flush, jump bundles captured (all zero)
    drive("jmp",       4'b0000, 2'b00, 2'b00, 1, 0, 0,  0,  0,  0,    2'b10, 1,  1,  1, 0);
    drive("idle2",     4'b0000, 2'b00, 2'b00, 0, 0, 0,  0,  0,  0,    2'b00, 1,  1,  0, 0);
    // Put nonzero bundles in flight before a mid-stream reset
    drive("lw7",       4'b1000, 2'b10, 2'b11, 0, 0, 0,  2,  7,  0,    2'b00, 1,  1,  0, 0);
    drive("rt2",       4'b0101, 2'b00, 2'b10, 0, 0, 0,  1,  2,  0,    2'b00, 1,  1,  0, 0);

    // Asynchronous reset between edges clears everything immediately
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    rst_n = 1'b1;
    id_EX = '0; id_MEM = '0; id_WB = '0;
    sb_reset();

    drive("post_rst",  4'b0101, 2'b00, 2'b10, 0, 0, 0,  1,  2,  0,    2'b00, 1,  1,  0, 0);
    drive("post_rst2", 4'b0000, 2'b00, 2'b00, 0, 0, 0,  0,  0,  0,    2'b00, 1,  1,  0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Pipelined control-bundle carrier and hazard/redirect unit that sits downstream of the ID-stage main decoder. It accepts the decoded EX/MEM/WB bundles and Jump/Branch/BranchNot flags each cycle. It registers them through the ID/EX, EX/MEM and MEM/WB control latches, and inserts bubbles on load-use hazards and taken control transfers. It drives PC-select, PC/IF-ID write enables and the IF/ID flush.

## Interface
Parameters:
- REG_W, 5, register-specifier width
- CNT_W, 16, statistics counter width (only with CTRL_PIPE_STATS_EN)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_EX  in  4  {ALUSrc, ALUOp[1:0], RegDst} from decoder
- id_MEM  in  2  {MemRead, MemWrite}
- id_WB  in  2  {RegWrite, MemToReg}
- id_Jump, id_Branch, id_BranchNot  in  1 each  decoder flags
- id_rs, id_rt  in  REG_W  source specifiers of instruction in ID
- ex_zero  in  1  ALU zero flag of instruction in EX
- ex_EX  out  4  ID/EX EX bundle
- ex_MEM, ex_WB  out  2  ID/EX MEM/WB bundles
- mem_MEM, mem_WB  out  2  EX/MEM bundles
- wb_WB  out  2  MEM/WB bundle
- pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target
- pc_write, ifid_write  out  1  enables for PC and IF/ID
- ifid_flush  out  1  clear IF/ID at next edge
- stall_cnt, flush_cnt  out  CNT_W  event counters (only with macro)

## Operation
- ID/EX also holds ex_rt (REG_W) plus ex_Branch and ex_BranchNot internally.
- Branch resolve (EX): take = ex_Branch&ex_zero | ex_BranchNot&~ex_zero.
- Load-use hazard: hz = ex_MEM[1] & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt). Evaluated only when take=0.
- Priority per cycle: take > hz > id_Jump > normal.
- take: pc_sel=01, ifid_flush=1, pc_write=1, ifid_write=1. ID/EX loads a bubble, squashing the wrong-path instruction in ID, including any jump.
- hz: pc_write=0, ifid_write=0, ifid_flush=0, pc_sel=00. ID/EX loads a bubble. The ID instruction is held and retried next cycle.
- id_Jump (no take, no hz): pc_sel=10, ifid_flush=1. ID/EX captures the jump's bundles, which are all zero.
- normal: pc_sel=00, pc_write=ifid_write=1, ifid_flush=0. ID/EX captures the id_* inputs.
- Bubble: all bundle bits, ex_rt, ex_Branch and ex_BranchNot are 0.
- EX/MEM and MEM/WB always advance; they are never stalled or flushed.
- The decoder's don't-care bits are driven 0 by the ID stage. The block does not sanitize X.

## Timing
- Reset (rst_n=0, asynchronous): every pipeline register clears to 0.
- Outputs during and after reset until the first edge: all bundles 0; pc_sel=00, pc_write=1, ifid_write=1, ifid_flush=0. Counters clear to 0.
- Bundle latency: id_* → ex_* 1 cycle, → mem_* 2 cycles, → wb_WB 3 cycles.
- pc_sel, pc_write, ifid_write and ifid_flush are combinational from the current ID/EX contents, id_* and ex_zero. They take effect at the next edge.
- A taken branch costs 2 bubbles: the IF instruction is flushed and the ID instruction is squashed.
- A jump costs 1 bubble. A load-use hazard costs exactly 1 stall cycle: after the bubble, ex_MEM[1]=0, so hz deasserts.
- Reset asserted mid-operation clears all stages immediately. The first post-reset cycle behaves as normal.

## Configuration
- CTRL_PIPE_STATS_EN defined:
  - stall_cnt increments on each cycle with hz=1 and take=0.
  - flush_cnt increments on each cycle with ifid_flush=1.
  - Both saturate at 2^CNT_W-1 and clear on reset.
- CTRL_PIPE_STATS_EN undefined: the counter ports and their logic are absent.

## Test plan
- Reset: drive rst_n=0 mid-stream with nonzero bundles in flight → all ex_/mem_/wb_ outputs read 0 immediately; pc_write=1; counters 0.
- R-type stream: id_EX=0101, id_WB=10 for one cycle → ex_EX=0101 at +1, mem_WB=10 at +2, wb_WB=10 at +3.
- Load-use: lw (MEM=10, WB=11, rt=8) then add with id_rs=8 → one cycle with pc_write=0, ifid_write=0 and ex bundle 0; the add enters EX next cycle; stall_cnt=1.
- Load to $0: lw with rt=0 followed by a user of rs=0 → no stall.
- BNE taken: id_BranchNot=1, then ex_zero=0 in EX → pc_sel=01, ifid_flush=1 and ID/EX bubble at the next edge; BEQ with ex_zero=0 → no redirect.
- Branch+jump collision: taken BEQ in EX while id_Jump=1 → pc_sel=01, the jump is squashed, and pc_sel never shows 10 for that jump.
